// File: rtl/snow64_main_mem_arb_pkg.sv
// Shared types and default widths for the Snow64 multi-port main memory.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The response struct is sized for the default data width and for up to
// eight requester ports. A top instance with a wider DATA_WIDTH needs
// DEF_DATA_WIDTH raised to match.
package PkgSnow64MainMemArb;

    localparam int DEF_DATA_WIDTH = 256;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int WIDTH__BYTE_EN = DEF_DATA_WIDTH / 8;
    localparam int WIDTH__DATA    = DEF_DATA_WIDTH;
    localparam int MAX_PORTS      = 8;
    localparam int WIDTH__PORT_ID = $clog2(MAX_PORTS);

    // One response pipeline stage.
    typedef struct packed {
        logic                      valid;
        logic [WIDTH__PORT_ID-1:0] port;
        logic                      wr;
        logic                      err;
        logic [WIDTH__DATA-1:0]    data;
    } StrcRsp;

endpackage

// File: rtl/snow64_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid port at/after the pointer.
// Latency: grant is combinational from req and the registered pointer.
// Backpressure: ungranted ports keep waiting; the pointer moves past each winner.
//
// Ports:
//   clk, rst_n  clock, async active-low reset (pointer returns to 0)
//   req         per-port request valid
//   grant       one-hot grant, all zero when nothing is requested
//   grant_vld   some port is granted this cycle
//   grant_idx   index of the granted port
module snow64_rr_arbiter #(
    parameter  int NUM_PORTS = 2,
    localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 grant_vld,
    output logic [PW-1:0]        grant_idx
);

    localparam logic [PW:0] NP = (PW + 1)'(NUM_PORTS);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW:0]   cand;
    logic [PW:0]   inc;

    // Scan NUM_PORTS candidates starting at ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, ptr} + (PW + 1)'(i);
            if (cand >= NP) begin
                cand = cand - NP;
            end
            if (!grant_vld && req[cand[PW-1:0]]) begin
                grant_vld              = 1'b1;
                grant_idx              = cand[PW-1:0];
                grant[cand[PW-1:0]]    = 1'b1;
            end
        end
    end

    always_comb begin
        inc     = {1'b0, grant_idx} + (PW + 1)'(1);
        ptr_nxt = (inc >= NP) ? '0 : inc[PW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_vld) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/snow64_main_mem_arb.sv
// Multi-port word-addressed main memory behind a round-robin valid/ready arbiter.
// Latency: response valid RD_LATENCY edges after the accept edge, in accept order.
// Backpressure: one accept per cycle via one-hot ready; responses are never stalled.
//
// Ports:
//   clk, rst_n     clock, async active-low reset (clears arbiter and response pipe)
//   in_req_valid   per-port request valid
//   in_req_wr      per-port write(1)/read(0)
//   in_addr        per-port word address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   in_data        per-port write data
//   in_byte_en     per-port byte enables
//   out_req_ready  one-hot grant, forced low during reset
//   out_rsp_*      response: valid, issuing port, write ack, range error, read data
module snow64_main_mem_arb
    import PkgSnow64MainMemArb::*;
#(
    parameter  int NUM_PORTS  = 2,
    parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter  int DEPTH      = 65536,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int RD_LATENCY = 1,
    localparam int PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int BE_W       = DATA_WIDTH / 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            in_req_valid,
    input  logic [NUM_PORTS-1:0]            in_req_wr,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] in_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS*BE_W-1:0]       in_byte_en,
    output logic [NUM_PORTS-1:0]            out_req_ready,
    output logic                            out_rsp_valid,
    output logic [PW-1:0]                   out_rsp_port,
    output logic                            out_rsp_wr,
    output logic                            out_rsp_err,
    output logic [DATA_WIDTH-1:0]           out_rsp_data
);

    localparam int                    IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    logic [NUM_PORTS-1:0]  grant;
    logic                  grant_vld;
    logic [PW-1:0]         sel;
    logic                  accept;

    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [BE_W-1:0]       sel_be;
    logic                  in_range;
    logic [IW-1:0]         mem_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    StrcRsp                rsp_in;
    StrcRsp                pipe [RD_LATENCY];

    snow64_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_req_valid),
        .grant     (grant),
        .grant_vld (grant_vld),
        .grant_idx (sel)
    );

    // Grant depends only on valid and the pointer; reset masks it so nothing
    // can be accepted (or written) while rst_n is low.
    assign out_req_ready = rst_n ? grant : '0;
    assign accept        = grant_vld & rst_n;

    assign sel_wr   = in_req_wr[sel];
    assign sel_addr = in_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data = in_data[sel*DATA_WIDTH +: DATA_WIDTH];
    assign sel_be   = in_byte_en[sel*BE_W +: BE_W];

    // Range check uses the full address; only then are the low bits trusted.
    assign in_range = {1'b0, sel_addr} < DEPTH_LIM;
    assign mem_idx  = sel_addr[IW-1:0];

    // Read sees the array before this edge's write, which is always from the
    // same (single) accepted request, so no forwarding is needed.
    assign rd_word = mem[mem_idx];

    // Array is intentionally not reset: committed data survives rst_n.
    always_ff @(posedge clk) begin
        if (accept && sel_wr && in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (sel_be[b]) begin
                    mem[mem_idx][b*8 +: 8] <= sel_data[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_in = '0;
        if (accept) begin
            rsp_in.valid = 1'b1;
            rsp_in.port  = WIDTH__PORT_ID'(sel);
            rsp_in.wr    = sel_wr;
            rsp_in.err   = !in_range;
            if (!sel_wr && in_range) begin
                rsp_in.data = WIDTH__DATA'(rd_word);
            end
        end
    end

    // Idle stages carry all-zero so outputs read 0 whenever nothing is due.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                pipe[s] <= '0;
            end
        end else begin
            pipe[0] <= rsp_in;
            for (int s = 1; s < RD_LATENCY; s++) begin
                pipe[s] <= pipe[s-1];
            end
        end
    end

    assign out_rsp_valid = pipe[RD_LATENCY-1].valid;
    assign out_rsp_port  = PW'(pipe[RD_LATENCY-1].port);
    assign out_rsp_wr    = pipe[RD_LATENCY-1].wr;
    assign out_rsp_err   = pipe[RD_LATENCY-1].err;
    assign out_rsp_data  = DATA_WIDTH'(pipe[RD_LATENCY-1].data);

    // Port-id bits above PW are always zero.
    logic unused_port_bits;
    assign unused_port_bits = ^pipe[RD_LATENCY-1].port;

endmodule

// File: tb/tb_snow64_main_mem_arb.sv
// Scoreboard bench for snow64_main_mem_arb: two instances share the stimulus.
// Instance A: RD_LATENCY=1, DEPTH=65536. Instance B: RD_LATENCY=3, DEPTH=1024.
// Stimulus pushes hand-computed responses; a monitor pops and compares them.
module tb_snow64_main_mem_arb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [1:0]   req_valid;
    logic [1:0]   req_wr;
    logic [31:0]  addr;
    logic [511:0] wdata;
    logic [63:0]  byte_en;

    logic [1:0]   rdy_a, rdy_b;
    logic         vld_a, port_a, wr_a, err_a;
    logic         vld_b, port_b, wr_b, err_b;
    logic [255:0] data_a, data_b;

    typedef struct {
        int           port;
        logic         wr;
        logic         err;
        logic [255:0] data;
        int           due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [255:0] w1, w2, w3, w4;

    snow64_main_mem_arb #(
        .NUM_PORTS(2), .ADDR_WIDTH(16), .DEPTH(65536), .DATA_WIDTH(256), .RD_LATENCY(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .in_req_valid(req_valid), .in_req_wr(req_wr),
        .in_addr(addr), .in_data(wdata), .in_byte_en(byte_en), .out_req_ready(rdy_a),
        .out_rsp_valid(vld_a), .out_rsp_port(port_a), .out_rsp_wr(wr_a),
        .out_rsp_err(err_a), .out_rsp_data(data_a)
    );

    snow64_main_mem_arb #(
        .NUM_PORTS(2), .ADDR_WIDTH(16), .DEPTH(1024), .DATA_WIDTH(256), .RD_LATENCY(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .in_req_valid(req_valid), .in_req_wr(req_wr),
        .in_addr(addr), .in_data(wdata), .in_byte_en(byte_en), .out_req_ready(rdy_b),
        .out_rsp_valid(vld_b), .out_rsp_port(port_b), .out_rsp_wr(wr_b),
        .out_rsp_err(err_b), .out_rsp_data(data_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [255:0] act,
                                  input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [255:0] dpat(input int i);
        return {8{32'hA5A5_0000 | 32'(i)}};
    endfunction

    // One request cycle: drive at negedge, check grant, push expected responses.
    task automatic step(input logic [1:0] vld, input logic [1:0] wr,
                        input logic [15:0] a0, input logic [15:0] a1,
                        input logic [255:0] d, input logic [31:0] be, input int gp,
                        input logic [255:0] ea, input logic erra,
                        input logic [255:0] eb, input logic errb);
        logic [1:0] er;
        exp_t       x;
        @(negedge clk);
        req_valid = vld;
        req_wr    = wr;
        addr      = {a1, a0};
        wdata     = {d, d};
        byte_en   = {be, be};
        #1;
        er = (gp < 0) ? 2'b00 : 2'(1 << gp);
        check("ready_a", 256'(rdy_a), 256'(er));
        check("ready_b", 256'(rdy_b), 256'(er));
        if (gp >= 0) begin
            x.port = gp;
            x.wr   = wr[gp];
            x.err  = erra;
            x.data = ea;
            x.due  = cyc + 1;
            qa.push_back(x);
            x.err  = errb;
            x.data = eb;
            x.due  = cyc + 3;
            qb.push_back(x);
        end
    endtask

    task automatic req1(input int p, input logic w, input logic [15:0] a,
                        input logic [255:0] d, input logic [31:0] be,
                        input logic [255:0] ea, input logic erra,
                        input logic [255:0] eb, input logic errb);
        step(2'(1 << p), {w, w}, a, a, d, be, p, ea, erra, eb, errb);
    endtask

    task automatic idle();
        step(2'b00, 2'b00, 16'h0, 16'h0, '0, '0, -1, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic mon(input int k, input logic v, input logic p, input logic w,
                       input logic e, input logic [255:0] d);
        string tag;
        exp_t  x;
        logic  have;
        tag  = (k == 0) ? "A" : "B";
        have = (k == 0) ? (qa.size() > 0) : (qb.size() > 0);
        if (have) x = (k == 0) ? qa[0] : qb[0];
        if (v) begin
            if (!have) begin
                check({tag, "_rsp_unexpected"}, 256'(v), 256'(0));
            end else begin
                if (k == 0) void'(qa.pop_front()); else void'(qb.pop_front());
                check({tag, "_rsp_port"}, 256'(p), 256'(x.port));
                check({tag, "_rsp_wr"},   256'(w), 256'(x.wr));
                check({tag, "_rsp_err"},  256'(e), 256'(x.err));
                check({tag, "_rsp_data"}, d, x.data);
                check({tag, "_rsp_cycle"}, 256'(cyc), 256'(x.due));
            end
        end else if (have && x.due <= cyc) begin
            check({tag, "_rsp_missing"}, 256'(v), 256'(1));
            if (k == 0) void'(qa.pop_front()); else void'(qb.pop_front());
        end else begin
            check({tag, "_idle_zero"}, 256'({p, w, e}) | d, '0);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            mon(0, vld_a, port_a, wr_a, err_a, data_a);
            mon(1, vld_b, port_b, wr_b, err_b, data_b);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        w1 = {8{32'hC0DE_12AB}};
        w2 = {w1[255:8], 8'hFF};
        w3 = {8{32'h3333_4444}};
        w4 = {8{32'h7E57_0BAD}};
        req_valid = 2'b11;
        req_wr    = 2'b00;
        addr      = '0;
        wdata     = '0;
        byte_en   = '0;

        // Reset: ready masked even with both ports valid, responses zero.
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready_a", 256'(rdy_a), '0);
        check("rst_ready_b", 256'(rdy_b), '0);
        check("rst_rsp_a", 256'({vld_a, port_a, wr_a, err_a}) | data_a, '0);
        check("rst_rsp_b", 256'({vld_b, port_b, wr_b, err_b}) | data_b, '0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 2'b00;

        // Full write then read back; partial byte write keeps other bytes.
        req1(0, 1'b1, 16'h0010, w1, 32'hFFFF_FFFF, '0, 1'b0, '0, 1'b0);
        req1(0, 1'b0, 16'h0010, '0, 32'hFFFF_FFFF, w1, 1'b0, w1, 1'b0);
        req1(1, 1'b1, 16'h0010, {256{1'b1}}, 32'h0000_0001, '0, 1'b0, '0, 1'b0);
        req1(0, 1'b0, 16'h0010, '0, 32'hFFFF_FFFF, w2, 1'b0, w2, 1'b0);
        req1(1, 1'b0, 16'h0010, '0, 32'hFFFF_FFFF, w2, 1'b0, w2, 1'b0);

        // Contention: pointer is 0, grants must alternate 0,1,0,1,0,1.
        for (int i = 0; i < 6; i++) begin
            step(2'b11, 2'b11, 16'h0020, 16'h0021, '0, '0, i % 2, '0, 1'b0, '0, 1'b0);
        end

        // Back-to-back writes then reads of 0..3.
        for (int i = 0; i < 4; i++) begin
            req1(0, 1'b1, 16'(i), dpat(i), 32'hFFFF_FFFF, '0, 1'b0, '0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            req1(0, 1'b0, 16'(i), '0, 32'hFFFF_FFFF, dpat(i), 1'b0, dpat(i), 1'b0);
        end
        idle();

        // Range boundary: 0x400 is out of range only for B; 0x3FF is in range.
        req1(0, 1'b1, 16'h0400, w3, 32'hFFFF_FFFF, '0, 1'b0, '0, 1'b1);
        req1(0, 1'b0, 16'h0400, '0, 32'hFFFF_FFFF, w3, 1'b0, '0, 1'b1);
        req1(0, 1'b0, 16'h0000, '0, 32'hFFFF_FFFF, dpat(0), 1'b0, dpat(0), 1'b0);
        req1(1, 1'b1, 16'h03FF, w4, 32'hFFFF_FFFF, '0, 1'b0, '0, 1'b0);
        req1(1, 1'b0, 16'h03FF, '0, 32'hFFFF_FFFF, w4, 1'b0, w4, 1'b0);
        idle();
        repeat (4) @(negedge clk);

        // Mid-flight reset: leave pointer at 1, B still holds two responses.
        req1(1, 1'b0, 16'h0001, '0, 32'hFFFF_FFFF, dpat(1), 1'b0, dpat(1), 1'b0);
        req1(0, 1'b0, 16'h0010, '0, 32'hFFFF_FFFF, w2, 1'b0, w2, 1'b0);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b11;
        qa.delete();
        qb.delete();
        #1;
        check("mid_rst_ready_a", 256'(rdy_a), '0);
        check("mid_rst_ready_b", 256'(rdy_b), '0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_quiet_a", 256'(vld_a), '0);
            check("post_rst_quiet_b", 256'(vld_b), '0);
        end

        // Pointer back at 0: port 0 wins first; data survived reset.
        step(2'b11, 2'b11, 16'h0020, 16'h0021, '0, '0, 0, '0, 1'b0, '0, 1'b0);
        step(2'b11, 2'b11, 16'h0020, 16'h0021, '0, '0, 1, '0, 1'b0, '0, 1'b0);
        req1(0, 1'b0, 16'h0010, '0, 32'hFFFF_FFFF, w2, 1'b0, w2, 1'b0);
        req1(1, 1'b0, 16'h0002, '0, 32'hFFFF_FFFF, dpat(2), 1'b0, dpat(2), 1'b0);
        idle();
        repeat (6) @(negedge clk);

        check("drain_a", 256'(qa.size()), '0);
        check("drain_b", 256'(qb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snow64_main_mem_arb.md
Name: snow64_main_mem_arb

Overview:
Multi-port, parametrised main memory for Snow64. NUM_PORTS requesters (instruction fetch, data LARs, DMA) share one word-addressed array through a round-robin arbiter with a valid/ready request handshake. Writes use per-byte enables. Every accepted request returns one response after a configurable RD_LATENCY pipeline. This block replaces the single-port, always-read main memory in the top-level SoC.

Parameters:
NUM_PORTS, 2, number of requester ports (1..8)
ADDR_WIDTH, 16, word-address width per port
DEPTH, 65536, words implemented (<= 2**ADDR_WIDTH); higher addresses are out of range
DATA_WIDTH, 256, bits per word (multiple of 8)
RD_LATENCY, 1, edges from accept to response (1..4)

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
in_req_valid  in  NUM_PORTS  per-port request valid
in_req_wr  in  NUM_PORTS  per-port write(1)/read(0)
in_addr  in  NUM_PORTS*ADDR_WIDTH  per-port word address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
in_data  in  NUM_PORTS*DATA_WIDTH  per-port write data
in_byte_en  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables, bit b covers data byte b
out_req_ready  out  NUM_PORTS  one-hot grant; request p accepted on edge where valid[p]&ready[p]
out_rsp_valid  out  1  response valid, one cycle per accepted request
out_rsp_port  out  clog2(NUM_PORTS) (min 1)  port that issued the response's request
out_rsp_wr  out  1  response is a write ack
out_rsp_err  out  1  request address >= DEPTH
out_rsp_data  out  DATA_WIDTH  read data; 0 for writes and errors

Behaviour:
- Reset (rst_n low, asynchronous): priority pointer=0; all response pipeline stages cleared; out_rsp_valid=0, out_rsp_port=0, out_rsp_wr=0, out_rsp_err=0, out_rsp_data=0. out_req_ready is forced to 0 while rst_n is low. The memory array is not reset; simulation initial contents are 0.
- Arbiter (combinational grant from registered pointer):
  - Scan ports starting at the pointer, wrapping modulo NUM_PORTS.
  - The first port with valid=1 gets ready=1; all others get ready=0.
  - If no port is valid, ready is all zero and the pointer holds.
  - On accept of port p, pointer <= (p+1) mod NUM_PORTS.
  - At most one accept per cycle.
  - ready[p] must not depend on in_req_wr, in_addr or in_data.
- Responses are never backpressured.
- Write accept (in range): on the accept edge, each byte b with byte_en[b]=1 is written; other bytes are kept. byte_en=0 is legal and produces a normal ack.
- Read accept (in range): data is the word contents at the accept edge, including all writes accepted on earlier edges.
- Out of range: a write is dropped and a read returns 0; both respond with out_rsp_err=1.
- Latency: a request accepted on edge E0 produces a response whose outputs become valid after edge E0+RD_LATENCY-1 and stay for exactly one cycle.
  - RD_LATENCY=1 gives a response in the cycle after the accept, matching the legacy timing.
  - The block accepts back-to-back requests; responses return in accept order, one per cycle, with no bubbles inserted.
  - When no response is due, out_rsp_valid=0 and the other response outputs hold 0.
- Reset asserted mid-operation discards in-flight responses; those requests are treated as never accepted. The array keeps all writes committed before reset.
- The address index uses only clog2(DEPTH) bits, after the range check on the full ADDR_WIDTH.

Decomposition:
- Package PkgSnow64MainMemArb holds:
  - DATA_WIDTH and ADDR_WIDTH defaults
  - WIDTH__BYTE_EN = DATA_WIDTH/8
  - WIDTH__PORT_ID
  - struct StrcRsp {valid, port, wr, err, data}, used for the pipeline stages
- Sub-module snow64_rr_arbiter holds the pointer register and one-hot grant logic, parametrised by NUM_PORTS. The memory array and response pipeline live in the top module.

Test Plan:
- Reset, then port0 writes addr 0x10 with data=0x..AB in byte0 and byte_en all-ones; RD_LATENCY=1 -> ack next cycle with wr=1, port=0, err=0; a later read of 0x10 returns 0x..AB.
- Write 0x10 with byte_en=0x00000001 and data=0xFF..FF -> a subsequent read returns the old word with only byte0=0xFF.
- Ports 0 and 1 both hold valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; responses come back with port ids in the same order.
- RD_LATENCY=3: 4 back-to-back reads of 0..3 -> out_rsp_valid high on 4 consecutive cycles starting 3 edges after the first accept, with data in order.
- DEPTH=1024: read addr 0x400 -> err=1, data=0; write 0x400 -> err=1, and a read of 0x000 is unchanged.
- Assert rst_n for 1 cycle while 2 responses are in flight (RD_LATENCY=3) -> no response appears afterwards; pointer=0, so port0 wins the next contention; earlier-written data persists.
